axi4_full_master_rw_engine: RTL and testbench
=============================================

Name: axi4_full_master_rw_engine

Overview:
- AXI4 full (memory-mapped) master performing one fixed-length INCR burst per start pulse on independent write and read paths.
- Exposes simple valid/ready user-side data ports.
- Sits between a stream adapter (stream-to-MM or MM-to-stream) and the system interconnect.

Parameters:
- C_M_TARGET_SLAVE_BASE_ADDR, 32'h00000000, added to every user address.
- C_M_AXI_BURST_LEN, 256, beats per burst; legal values 4, 8, 16, 32, 64, 128, 256.
- C_M_AXI_ID_WIDTH, 1, AXI ID width.
- C_M_AXI_ADDR_WIDTH, 32, address width.
- C_M_AXI_DATA_WIDTH, 32, data width (32/64/128).
- C_M_AXI_AWUSER_WIDTH, C_M_AXI_ARUSER_WIDTH, C_M_AXI_WUSER_WIDTH, C_M_AXI_RUSER_WIDTH, C_M_AXI_BUSER_WIDTH: all 0; USER widths, treated as minimum 1.

Ports:
One clock; reset is synchronous and active-high.
- M_AXI_ACLK  in  1  clock.
- M_AXI_ARESET  in  1  synchronous active-high reset.
- write_address  in  ADDR  byte offset of write burst.
- write_start  in  1  start write (one-cycle pulse).
- write_data  in  DATA  beat data.
- write_data_valid  in  1  write_data valid.
- write_ready  out  1  beat accepted this cycle when write_data_valid is high.
- write_data_last  out  1  last beat accepted.
- write_end  out  1  one-cycle pulse on B handshake.
- read_address  in  ADDR  byte offset of read burst.
- read_start  in  1  start read (one-cycle pulse).
- read_ready  in  1  user can take read data.
- read_data  out  DATA  beat data.
- read_data_valid  out  1  beat delivered.
- read_data_last  out  1  last beat delivered.
- read_end  out  1  one-cycle pulse after last read beat.
- output_idle  out  1  no transaction in progress.
- output_error  out  1  sticky error flag.
- M_AXI_AW*  AWID, AWADDR, AWLEN[8], AWSIZE[3], AWBURST[2], AWLOCK, AWCACHE[4], AWPROT[3], AWQOS[4], AWUSER, AWVALID out; AWREADY in.
- M_AXI_W*  WDATA, WSTRB, WLAST, WUSER, WVALID out; WREADY in.
- M_AXI_B*  BID, BRESP[2], BUSER, BVALID in; BREADY out.
- M_AXI_AR*  same set as AW, with the AR prefix.
- M_AXI_R*  RID, RDATA, RRESP[2], RLAST, RUSER, RVALID in; RREADY out.

Behaviour:
- Constant outputs:
  - ID = 0, LEN = BURST_LEN-1, SIZE = clog2(DATA/8), BURST = 2'b01 (INCR).
  - LOCK = 0, CACHE = 4'b0011, PROT = 0, QOS = 0, USER = 0, WSTRB = all ones.
- Reset: all VALIDs, BREADY, RREADY, write_end, read_end, *_last, read_data_valid and output_error are 0; output_idle = 1; beat counters = 0.
- Write FSM, states W_IDLE → W_ADDR → W_DATA → W_RESP → W_IDLE:
  - write_start in W_IDLE latches AWADDR = BASE + write_address and registers AWVALID next cycle (W_ADDR).
  - AWVALID drops on AWREADY; go to W_DATA.
  - In W_DATA: WVALID = write_data_valid; WDATA = write_data; write_ready = M_AXI_WREADY.
  - Beat counts on WVALID & WREADY.
  - WLAST = (count == BURST_LEN-1) while in W_DATA; write_data_last = WLAST & WVALID & WREADY.
  - After the last beat go to W_RESP with BREADY = 1.
  - On BVALID: write_end pulses 1 cycle; return to W_IDLE.
  - BRESP[1] = 1 sets output_error.
- Read FSM, states R_IDLE → R_ADDR → R_DATA → R_IDLE:
  - read_start latches ARADDR = BASE + read_address.
  - ARVALID is held until ARREADY.
  - In R_DATA: RREADY = read_ready; read_data = RDATA; read_data_valid = RVALID & RREADY.
  - read_data_last = read_data_valid & RLAST.
  - After the last beat, read_end pulses 1 cycle; return to R_IDLE.
  - RRESP[1] = 1 on any beat sets output_error.
  - RLAST arriving at a beat count other than BURST_LEN-1 also sets output_error; the burst still ends on RLAST.
- Write and read paths are fully independent. write_start and read_start in the same cycle both start.
- A start seen while its path is not idle is ignored.
- output_idle = (write FSM idle) & (read FSM idle), combinational.
- output_error stays set until reset.
- Reset mid-burst: all FSMs return to idle immediately, VALIDs drop, counters clear. Reset takes priority over all other inputs.
- Address arithmetic wraps modulo 2^ADDR; 4 KB boundary crossing is the caller's responsibility.

Test Plan:
- Write, BURST_LEN = 4, base 0, write_address = 0x100, data 1, 2, 3, 4, slave always ready → AWADDR = 0x100, AWLEN = 3; 4 W beats with WLAST on beat 4; write_end pulses once after BVALID; output_idle returns to 1.
- Write with write_data_valid and WREADY toggling randomly → exactly 4 handshakes; data in order; WLAST only on the 4th handshake.
- Read, BURST_LEN = 4, read_address = 0x200, slave returns A0..A3 with RLAST on the 4th, read_ready held at 0 for 3 cycles then 1 → RREADY follows read_ready; 4 read_data_valid beats; read_data_last with A3; read_end pulses once.
- BRESP = 2'b10 on write, or RRESP = 2'b11 on read → output_error goes to 1 and stays there until M_AXI_ARESET.
- write_start and read_start asserted in the same cycle, then a second write_start mid-burst → both bursts complete; the second start is ignored (one AW only).
- Assert M_AXI_ARESET after 2 write beats → next cycle AWVALID = WVALID = 0, output_idle = 1, output_error = 0; a new write burst then runs normally.

Source files
------------

// File: rtl/axi4_full_master_rw_engine.sv
// AXI4 full master: one fixed-length INCR burst per start pulse on independent
// write and read paths, with simple valid/ready user-side data ports.
module axi4_full_master_rw_engine #(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h0000_0000,
  parameter int C_M_AXI_BURST_LEN    = 256,
  parameter int C_M_AXI_ID_WIDTH     = 1,
  parameter int C_M_AXI_ADDR_WIDTH   = 32,
  parameter int C_M_AXI_DATA_WIDTH   = 32,
  parameter int C_M_AXI_AWUSER_WIDTH = 0,
  parameter int C_M_AXI_ARUSER_WIDTH = 0,
  parameter int C_M_AXI_WUSER_WIDTH  = 0,
  parameter int C_M_AXI_RUSER_WIDTH  = 0,
  parameter int C_M_AXI_BUSER_WIDTH  = 0
) (
  input  logic                                  M_AXI_ACLK,
  input  logic                                  M_AXI_ARESET,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]         write_address,
  input  logic                                  write_start,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]         write_data,
  input  logic                                  write_data_valid,
  output logic                                  write_ready,
  output logic                                  write_data_last,
  output logic                                  write_end,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]         read_address,
  input  logic                                  read_start,
  input  logic                                  read_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         read_data,
  output logic                                  read_data_valid,
  output logic                                  read_data_last,
  output logic                                  read_end,
  output logic                                  output_idle,
  output logic                                  output_error,
  output logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [7:0]                            M_AXI_AWLEN,
  output logic [2:0]                            M_AXI_AWSIZE,
  output logic [1:0]                            M_AXI_AWBURST,
  output logic                                  M_AXI_AWLOCK,
  output logic [3:0]                            M_AXI_AWCACHE,
  output logic [2:0]                            M_AXI_AWPROT,
  output logic [3:0]                            M_AXI_AWQOS,
  output logic [((C_M_AXI_AWUSER_WIDTH > 0) ? C_M_AXI_AWUSER_WIDTH : 1)-1:0] M_AXI_AWUSER,
  output logic                                  M_AXI_AWVALID,
  input  logic                                  M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                                  M_AXI_WLAST,
  output logic [((C_M_AXI_WUSER_WIDTH > 0) ? C_M_AXI_WUSER_WIDTH : 1)-1:0] M_AXI_WUSER,
  output logic                                  M_AXI_WVALID,
  input  logic                                  M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_BID,
  input  logic [1:0]                            M_AXI_BRESP,
  input  logic [((C_M_AXI_BUSER_WIDTH > 0) ? C_M_AXI_BUSER_WIDTH : 1)-1:0] M_AXI_BUSER,
  input  logic                                  M_AXI_BVALID,
  output logic                                  M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [7:0]                            M_AXI_ARLEN,
  output logic [2:0]                            M_AXI_ARSIZE,
  output logic [1:0]                            M_AXI_ARBURST,
  output logic                                  M_AXI_ARLOCK,
  output logic [3:0]                            M_AXI_ARCACHE,
  output logic [2:0]                            M_AXI_ARPROT,
  output logic [3:0]                            M_AXI_ARQOS,
  output logic [((C_M_AXI_ARUSER_WIDTH > 0) ? C_M_AXI_ARUSER_WIDTH : 1)-1:0] M_AXI_ARUSER,
  output logic                                  M_AXI_ARVALID,
  input  logic                                  M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]           M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                            M_AXI_RRESP,
  input  logic                                  M_AXI_RLAST,
  input  logic [((C_M_AXI_RUSER_WIDTH > 0) ? C_M_AXI_RUSER_WIDTH : 1)-1:0] M_AXI_RUSER,
  input  logic                                  M_AXI_RVALID,
  output logic                                  M_AXI_RREADY
);

  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam logic [AW-1:0] BASE_ADDR = AW'(C_M_TARGET_SLAVE_BASE_ADDR);
  localparam logic [7:0] AXLEN  = 8'(C_M_AXI_BURST_LEN - 1);
  localparam logic [2:0] AXSIZE = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));
  localparam logic [8:0] LAST_BEAT = 9'(C_M_AXI_BURST_LEN - 1);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_ADDR = 2'd1;
  localparam logic [1:0] W_DATA = 2'd2;
  localparam logic [1:0] W_RESP = 2'd3;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_ADDR = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  logic [1:0]    wstate_q, wstate_d;
  logic [AW-1:0] awaddr_q, awaddr_d;
  logic [8:0]    wcnt_q, wcnt_d;
  logic          wend_q, wend_d;

  logic [1:0]    rstate_q, rstate_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [8:0]    rcnt_q, rcnt_d;
  logic          rend_q, rend_d;

  logic          err_q, err_d;
  logic          w_hs, b_hs, r_hs;
  logic          unused_inputs;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWLEN   = AXLEN;
  assign M_AXI_AWSIZE  = AXSIZE;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'b0011;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_AWQOS   = 4'b0000;
  assign M_AXI_AWUSER  = '0;
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_WUSER   = '0;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARLEN   = AXLEN;
  assign M_AXI_ARSIZE  = AXSIZE;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'b0011;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_ARQOS   = 4'b0000;
  assign M_AXI_ARUSER  = '0;

  // Response IDs, user bits and the low response bit carry nothing this master acts on
  assign unused_inputs = ^{M_AXI_BID, M_AXI_BRESP[0], M_AXI_BUSER,
                           M_AXI_RID, M_AXI_RRESP[0], M_AXI_RUSER};

  assign M_AXI_AWADDR    = awaddr_q;
  assign M_AXI_AWVALID   = (wstate_q == W_ADDR);
  assign M_AXI_WDATA     = write_data;
  assign M_AXI_WVALID    = (wstate_q == W_DATA) & write_data_valid;
  assign M_AXI_WLAST     = (wstate_q == W_DATA) & (wcnt_q == LAST_BEAT);
  assign M_AXI_BREADY    = (wstate_q == W_RESP);
  assign write_ready     = (wstate_q == W_DATA) & M_AXI_WREADY;
  assign w_hs            = M_AXI_WVALID & M_AXI_WREADY;
  assign b_hs            = M_AXI_BVALID & M_AXI_BREADY;
  assign write_data_last = M_AXI_WLAST & w_hs;
  assign write_end       = wend_q;

  assign M_AXI_ARADDR    = araddr_q;
  assign M_AXI_ARVALID   = (rstate_q == R_ADDR);
  assign M_AXI_RREADY    = (rstate_q == R_DATA) & read_ready;
  assign r_hs            = M_AXI_RVALID & M_AXI_RREADY;
  assign read_data       = M_AXI_RDATA;
  assign read_data_valid = r_hs;
  assign read_data_last  = r_hs & M_AXI_RLAST;
  assign read_end        = rend_q;

  assign output_idle  = (wstate_q == W_IDLE) & (rstate_q == R_IDLE);
  assign output_error = err_q;
  // A short burst (RLAST before the final counted beat) is flagged like a slave error
  assign err_d = err_q | (b_hs & M_AXI_BRESP[1])
               | (r_hs & (M_AXI_RRESP[1] | (M_AXI_RLAST & (rcnt_q != LAST_BEAT))));

  // Write path sequencing
  always_comb begin
    wstate_d = wstate_q;
    awaddr_d = awaddr_q;
    wcnt_d   = wcnt_q;
    wend_d   = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (write_start) begin
          awaddr_d = BASE_ADDR + write_address;
          wstate_d = W_ADDR;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_ADDR: begin
        if (M_AXI_AWREADY) begin
          wstate_d = W_DATA;
        end else begin
          wstate_d = W_ADDR;
        end
      end
      W_DATA: begin
        if (w_hs && (wcnt_q == LAST_BEAT)) begin
          wcnt_d   = 9'd0;
          wstate_d = W_RESP;
        end else if (w_hs) begin
          wcnt_d = wcnt_q + 9'd1;
        end else begin
          wcnt_d = wcnt_q;
        end
      end
      W_RESP: begin
        if (M_AXI_BVALID) begin
          wend_d   = 1'b1;
          wstate_d = W_IDLE;
        end else begin
          wstate_d = W_RESP;
        end
      end
      default: begin
        wstate_d = W_IDLE;
        wcnt_d   = 9'd0;
      end
    endcase
  end

  // Read path sequencing; the burst always terminates on RLAST
  always_comb begin
    rstate_d = rstate_q;
    araddr_d = araddr_q;
    rcnt_d   = rcnt_q;
    rend_d   = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (read_start) begin
          araddr_d = BASE_ADDR + read_address;
          rstate_d = R_ADDR;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_ADDR: begin
        if (M_AXI_ARREADY) begin
          rstate_d = R_DATA;
        end else begin
          rstate_d = R_ADDR;
        end
      end
      R_DATA: begin
        if (r_hs && M_AXI_RLAST) begin
          rcnt_d   = 9'd0;
          rend_d   = 1'b1;
          rstate_d = R_IDLE;
        end else if (r_hs) begin
          rcnt_d = rcnt_q + 9'd1;
        end else begin
          rcnt_d = rcnt_q;
        end
      end
      default: begin
        rstate_d = R_IDLE;
        rcnt_d   = 9'd0;
      end
    endcase
  end

  // State registers with synchronous reset taking priority
  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      wstate_q <= W_IDLE;
      awaddr_q <= '0;
      wcnt_q   <= 9'd0;
      wend_q   <= 1'b0;
      rstate_q <= R_IDLE;
      araddr_q <= '0;
      rcnt_q   <= 9'd0;
      rend_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      awaddr_q <= awaddr_d;
      wcnt_q   <= wcnt_d;
      wend_q   <= wend_d;
      rstate_q <= rstate_d;
      araddr_q <= araddr_d;
      rcnt_q   <= rcnt_d;
      rend_q   <= rend_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4_full_master_rw_engine.sv
// Directed self-checking bench for axi4_full_master_rw_engine with BURST_LEN = 4.
module tb_axi4_full_master_rw_engine;

  logic        M_AXI_ACLK;
  logic        M_AXI_ARESET;
  logic [31:0] write_address;
  logic        write_start;
  logic [31:0] write_data;
  logic        write_data_valid;
  logic        write_ready;
  logic        write_data_last;
  logic        write_end;
  logic [31:0] read_address;
  logic        read_start;
  logic        read_ready;
  logic [31:0] read_data;
  logic        read_data_valid;
  logic        read_data_last;
  logic        read_end;
  logic        output_idle;
  logic        output_error;
  logic        M_AXI_AWID;
  logic [31:0] M_AXI_AWADDR;
  logic [7:0]  M_AXI_AWLEN;
  logic [2:0]  M_AXI_AWSIZE;
  logic [1:0]  M_AXI_AWBURST;
  logic        M_AXI_AWLOCK;
  logic [3:0]  M_AXI_AWCACHE;
  logic [2:0]  M_AXI_AWPROT;
  logic [3:0]  M_AXI_AWQOS;
  logic        M_AXI_AWUSER;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WLAST;
  logic        M_AXI_WUSER;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic        M_AXI_BID;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BUSER;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;
  logic        M_AXI_ARID;
  logic [31:0] M_AXI_ARADDR;
  logic [7:0]  M_AXI_ARLEN;
  logic [2:0]  M_AXI_ARSIZE;
  logic [1:0]  M_AXI_ARBURST;
  logic        M_AXI_ARLOCK;
  logic [3:0]  M_AXI_ARCACHE;
  logic [2:0]  M_AXI_ARPROT;
  logic [3:0]  M_AXI_ARQOS;
  logic        M_AXI_ARUSER;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic        M_AXI_RID;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RLAST;
  logic        M_AXI_RUSER;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;

  int n_checks = 0;
  int n_errors = 0;
  int aw_hs = 0, ar_hs = 0, wend_n = 0, rend_n = 0;
  int aw0, ar0, wend0, rend0;

  axi4_full_master_rw_engine #(
    .C_M_TARGET_SLAVE_BASE_ADDR(32'h0000_0000),
    .C_M_AXI_BURST_LEN(4)
  ) dut (
    .M_AXI_ACLK(M_AXI_ACLK), .M_AXI_ARESET(M_AXI_ARESET),
    .write_address(write_address), .write_start(write_start),
    .write_data(write_data), .write_data_valid(write_data_valid),
    .write_ready(write_ready), .write_data_last(write_data_last), .write_end(write_end),
    .read_address(read_address), .read_start(read_start), .read_ready(read_ready),
    .read_data(read_data), .read_data_valid(read_data_valid),
    .read_data_last(read_data_last), .read_end(read_end),
    .output_idle(output_idle), .output_error(output_error),
    .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
    .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
    .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
    .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
    .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
    .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARLOCK(M_AXI_ARLOCK),
    .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARUSER(M_AXI_ARUSER), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RUSER(M_AXI_RUSER), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  initial M_AXI_ACLK = 1'b0;
  always #5 M_AXI_ACLK = ~M_AXI_ACLK;

  // Inputs change 2 time units after posedge, so negedge sees settled handshakes
  always @(negedge M_AXI_ACLK) begin
    if (M_AXI_AWVALID && M_AXI_AWREADY) aw_hs++;
    if (M_AXI_ARVALID && M_AXI_ARREADY) ar_hs++;
    if (write_end) wend_n++;
    if (read_end) rend_n++;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge M_AXI_ACLK);
    #2;
  endtask

  task automatic snap();
    aw0 = aw_hs; ar0 = ar_hs; wend0 = wend_n; rend0 = rend_n;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [31:0] d0,
                           input logic [15:0] vpat, input logic [15:0] rpat,
                           input logic [1:0] bresp);
    int beat;
    int cyc;
    logic hs;
    beat = 0;
    cyc  = 0;
    step(); write_address = addr; write_start = 1'b1;
    step(); write_start = 1'b0; #1;
    check_eq("awvalid", 64'(M_AXI_AWVALID), 64'd1);
    check_eq("awaddr", 64'(M_AXI_AWADDR), 64'(addr));
    M_AXI_AWREADY = 1'b1;
    step(); M_AXI_AWREADY = 1'b0; #1;
    check_eq("awvalid_drop", 64'(M_AXI_AWVALID), 64'd0);
    while (beat < 4 && cyc < 48) begin
      write_data       = d0 + 32'(beat);
      write_data_valid = vpat[cyc % 16];
      M_AXI_WREADY     = rpat[cyc % 16];
      #1;
      hs = write_data_valid & M_AXI_WREADY;
      check_eq("wvalid", 64'(M_AXI_WVALID), 64'(write_data_valid));
      check_eq("write_ready", 64'(write_ready), 64'(M_AXI_WREADY));
      check_eq("wlast", 64'(M_AXI_WLAST), 64'(beat == 3));
      check_eq("write_data_last", 64'(write_data_last), 64'(hs && beat == 3));
      if (hs) begin
        check_eq("wdata", 64'(M_AXI_WDATA), 64'(d0 + 32'(beat)));
        beat++;
      end
      step();
      cyc++;
    end
    write_data_valid = 1'b0;
    M_AXI_WREADY     = 1'b0;
    check_eq("w_beats", 64'(beat), 64'd4);
    #1 check_eq("bready", 64'(M_AXI_BREADY), 64'd1);
    M_AXI_BVALID = 1'b1; M_AXI_BRESP = bresp;
    step(); M_AXI_BVALID = 1'b0; M_AXI_BRESP = 2'b00; #1;
    check_eq("write_end_pulse", 64'(write_end), 64'd1);
    check_eq("bready_drop", 64'(M_AXI_BREADY), 64'd0);
    step(); #1;
    check_eq("write_end_low", 64'(write_end), 64'd0);
  endtask

  task automatic run_read(input logic [31:0] addr, input int rdy_delay, input int bad_beat);
    int beat;
    int cyc;
    beat = 0;
    cyc  = 0;
    step(); read_address = addr; read_start = 1'b1;
    step(); read_start = 1'b0; #1;
    check_eq("arvalid", 64'(M_AXI_ARVALID), 64'd1);
    check_eq("araddr", 64'(M_AXI_ARADDR), 64'(addr));
    M_AXI_ARREADY = 1'b1;
    step(); M_AXI_ARREADY = 1'b0; #1;
    check_eq("arvalid_drop", 64'(M_AXI_ARVALID), 64'd0);
    while (beat < 4 && cyc < 48) begin
      M_AXI_RVALID = 1'b1;
      M_AXI_RDATA  = 32'hA0 + 32'(beat);
      M_AXI_RLAST  = (beat == 3);
      M_AXI_RRESP  = (beat == bad_beat) ? 2'b11 : 2'b00;
      read_ready   = (cyc >= rdy_delay);
      #1;
      check_eq("rready", 64'(M_AXI_RREADY), 64'(read_ready));
      check_eq("read_data_valid", 64'(read_data_valid), 64'(read_ready));
      check_eq("read_data_last", 64'(read_data_last), 64'(read_ready && beat == 3));
      if (read_ready) begin
        check_eq("read_data", 64'(read_data), 64'(32'hA0 + 32'(beat)));
        beat++;
      end
      step();
      cyc++;
    end
    M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0; M_AXI_RRESP = 2'b00; read_ready = 1'b0;
    check_eq("r_beats", 64'(beat), 64'd4);
    #1 check_eq("read_end_pulse", 64'(read_end), 64'd1);
    step(); #1;
    check_eq("read_end_low", 64'(read_end), 64'd0);
  endtask

  initial begin
    M_AXI_ARESET = 1'b1;
    write_address = '0; write_start = 1'b0; write_data = '0; write_data_valid = 1'b0;
    read_address = '0; read_start = 1'b0; read_ready = 1'b0;
    M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_ARREADY = 1'b0;
    M_AXI_BID = 1'b0; M_AXI_BRESP = 2'b00; M_AXI_BUSER = 1'b0; M_AXI_BVALID = 1'b0;
    M_AXI_RID = 1'b0; M_AXI_RDATA = '0; M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0;
    M_AXI_RUSER = 1'b0; M_AXI_RVALID = 1'b0;

    step(); step(); #1;
    check_eq("rst_valids", 64'({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                M_AXI_ARVALID, M_AXI_RREADY}), 64'd0);
    check_eq("rst_pulses", 64'({write_end, read_end, write_data_last,
                                read_data_last, read_data_valid}), 64'd0);
    check_eq("rst_idle", 64'(output_idle), 64'd1);
    check_eq("rst_error", 64'(output_error), 64'd0);
    check_eq("aw_const", 64'({M_AXI_AWID, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST,
                              M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS,
                              M_AXI_AWUSER}),
             64'({1'b0, 8'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0}));
    check_eq("ar_const", 64'({M_AXI_ARID, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
                              M_AXI_ARLOCK, M_AXI_ARCACHE, M_AXI_ARPROT, M_AXI_ARQOS,
                              M_AXI_ARUSER}),
             64'({1'b0, 8'd3, 3'd2, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0}));
    check_eq("wstrb_wuser", 64'({M_AXI_WSTRB, M_AXI_WUSER}), 64'(5'b11110));
    M_AXI_ARESET = 1'b0;

    // Plain write burst, slave always ready
    snap();
    run_write(32'h100, 32'h1, 16'hFFFF, 16'hFFFF, 2'b00);
    check_eq("w1_idle", 64'(output_idle), 64'd1);
    check_eq("w1_aw_count", 64'(aw_hs - aw0), 64'd1);
    check_eq("w1_wend_count", 64'(wend_n - wend0), 64'd1);
    check_eq("w1_error", 64'(output_error), 64'd0);

    // Stalled write: valid and ready toggle independently
    run_write(32'h140, 32'h11, 16'b1011_0110_1101_0101, 16'b0110_1101_1011_1010, 2'b00);
    check_eq("w2_idle", 64'(output_idle), 64'd1);

    // Read with read_ready held low for the first 3 cycles
    snap();
    run_read(32'h200, 3, -1);
    check_eq("r1_idle", 64'(output_idle), 64'd1);
    check_eq("r1_rend_count", 64'(rend_n - rend0), 64'd1);
    check_eq("r1_error", 64'(output_error), 64'd0);

    // Concurrent start, plus an extra write_start mid-burst that must be ignored
    snap();
    fork
      run_write(32'h300, 32'h21, 16'hFFFF, 16'hFFFF, 2'b00);
      run_read(32'h400, 0, -1);
      begin
        repeat (4) step();
        write_address = 32'h500; write_start = 1'b1;
        step(); write_start = 1'b0;
      end
    join
    repeat (3) step();
    #1;
    check_eq("cc_aw_count", 64'(aw_hs - aw0), 64'd1);
    check_eq("cc_ar_count", 64'(ar_hs - ar0), 64'd1);
    check_eq("cc_wend_count", 64'(wend_n - wend0), 64'd1);
    check_eq("cc_rend_count", 64'(rend_n - rend0), 64'd1);
    check_eq("cc_idle", 64'(output_idle), 64'd1);

    // SLVERR on B sets the sticky error; a clean read afterwards leaves it set
    run_write(32'h600, 32'h31, 16'hFFFF, 16'hFFFF, 2'b10);
    #1 check_eq("bresp_error", 64'(output_error), 64'd1);
    run_read(32'h700, 1, -1);
    #1 check_eq("error_sticky", 64'(output_error), 64'd1);

    // Reset after two write beats
    step(); write_address = 32'h800; write_start = 1'b1;
    step(); write_start = 1'b0; M_AXI_AWREADY = 1'b1;
    step(); M_AXI_AWREADY = 1'b0; write_data_valid = 1'b1; write_data = 32'h55; M_AXI_WREADY = 1'b1;
    step(); step();
    #1 check_eq("pre_rst_wvalid", 64'(M_AXI_WVALID), 64'd1);
    M_AXI_ARESET = 1'b1;
    step(); #1;
    check_eq("mid_rst_awvalid", 64'(M_AXI_AWVALID), 64'd0);
    check_eq("mid_rst_wvalid", 64'(M_AXI_WVALID), 64'd0);
    check_eq("mid_rst_idle", 64'(output_idle), 64'd1);
    check_eq("mid_rst_error", 64'(output_error), 64'd0);
    M_AXI_ARESET = 1'b0; write_data_valid = 1'b0; M_AXI_WREADY = 1'b0;
    run_write(32'h900, 32'h41, 16'hFFFF, 16'hFFFF, 2'b00);
    check_eq("post_rst_idle", 64'(output_idle), 64'd1);
    check_eq("post_rst_error", 64'(output_error), 64'd0);

    // SLVERR-class RRESP on one read beat
    run_read(32'hA00, 0, 1);
    #1 check_eq("rresp_error", 64'(output_error), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
